// File: rtl/paralelo_serial_n.sv
// paralelo_serial_n: serialises LANES parallel words of WIDTH bits onto
// LANES serial lines from a single bit-rate clock. A one-entry hold buffer
// with a valid/ready handshake feeds the shift registers, a sync preamble of
// SYNC_WORDS idle symbols follows reset, and IDLE_SYM is inserted whenever
// no word is waiting at a word boundary.
// Optional build macro: PS_LSB_FIRST_EN sends every word LSB first
// (default build sends MSB first).
module paralelo_serial_n #(
  parameter int               WIDTH      = 8,
  parameter int               LANES      = 1,
  parameter logic [WIDTH-1:0] IDLE_SYM   = 8'hBC,
  parameter int               SYNC_WORDS = 2
) (
  input  logic                   clk_32f,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [LANES-1:0]       data_out,
  output logic                   sym_start
);

  localparam int                CNT_W     = $clog2(WIDTH);
  localparam int                SC_W      = $clog2(SYNC_WORDS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(WIDTH - 1);
  localparam logic [SC_W-1:0]   SYNC_LAST = SC_W'(SYNC_WORDS - 1);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SC_W-1:0]        sync_cnt;
  logic [SC_W-1:0]        sync_cnt_next;
  logic [CNT_W-1:0]       bit_cnt;
  logic [LANES*WIDTH-1:0] hold_data;
  logic                   hold_valid;
  logic                   load;
  logic                   accept;

  // A word boundary occurs whenever the bit counter sits at zero; reset
  // overrides it inside each sequential block.
  assign load      = (bit_cnt == '0);
  assign ready_out = (state == ACTIVE) && (!hold_valid || load);
  assign accept    = valid_in && ready_out;

  // Bit counter and word-start marker.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt   <= '0;
      sym_start <= 1'b0;
    end else begin
      bit_cnt   <= (bit_cnt == CNT_MAX) ? '0 : bit_cnt + 1'b1;
      sym_start <= load;
    end
  end

  // State register for the sync-preamble FSM.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state    <= SYNC;
      sync_cnt <= '0;
    end else begin
      state    <= state_next;
      sync_cnt <= sync_cnt_next;
    end
  end

  // Next-state logic: count preamble words, then stay ACTIVE until reset.
  always_comb begin
    state_next    = state;
    sync_cnt_next = sync_cnt;
    if (state == SYNC && load) begin
      sync_cnt_next = sync_cnt + 1'b1;
      if (sync_cnt == SYNC_LAST) begin
        state_next = ACTIVE;
      end
    end
  end

  // Hold-buffer occupancy: set on accept, cleared when drained at a boundary.
  // An accept on a boundary refills the entry being drained in the same edge.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
    end else if (load && state == ACTIVE) begin
      hold_valid <= 1'b0;
    end
  end

  // Hold-buffer payload; only meaningful while hold_valid is set.
  always_ff @(posedge clk_32f) begin
    if (accept) begin
      hold_data <= data_in;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] shreg;

    // Per-lane shift register: load at the boundary, otherwise shift toward
    // the output bit.
    always_ff @(posedge clk_32f) begin
      if (reset) begin
        shreg <= '0;
      end else if (load) begin
        if (state == ACTIVE && hold_valid) begin
          shreg <= hold_data[k*WIDTH +: WIDTH];
        end else begin
          shreg <= IDLE_SYM;
        end
      end else begin
`ifdef PS_LSB_FIRST_EN
        shreg <= {1'b0, shreg[WIDTH-1:1]};
`else
        shreg <= {shreg[WIDTH-2:0], 1'b0};
`endif
      end
    end

`ifdef PS_LSB_FIRST_EN
    assign data_out[k] = shreg[0];
`else
    assign data_out[k] = shreg[WIDTH-1];
`endif
  end

endmodule

// File: tb/tb_paralelo_serial_n.sv
// Testbench for paralelo_serial_n (WIDTH=8, LANES=2, SYNC_WORDS=2, IDLE 8'hBC).
// Accepted words are queued with the word slot they must occupy; a monitor
// reassembles each serial word and compares it against the queue or IDLE.
module tb_paralelo_serial_n;

  localparam int          WIDTH      = 8;
  localparam int          LANES      = 2;
  localparam int          SYNC_WORDS = 2;
  localparam logic [7:0]  IDLE       = 8'hBC;
  localparam logic [15:0] IDLE_ALL   = {IDLE, IDLE};

  logic        clk_32f  = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] data_in  = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [1:0]  data_out;
  logic        sym_start;

  always #5 clk_32f = ~clk_32f;

  paralelo_serial_n #(
    .WIDTH(WIDTH), .LANES(LANES), .IDLE_SYM(IDLE), .SYNC_WORDS(SYNC_WORDS)
  ) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .sym_start(sym_start)
  );

  typedef struct {
    int          slot;
    logic [15:0] word;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  logic rst_q   = 1'b1;
  bit   started = 1'b0;
  int   pos     = -1;
  int   widx    = 0;
  logic [15:0] mw   = '0;
  logic [15:0] expw = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge bookkeeping: cyc counts edges since reset release.
  always @(posedge clk_32f) begin
    rst_q   = reset;
    started = 1'b1;
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  // Monitor: reassemble words per lane and compare with the scoreboard.
  initial begin
    forever begin
      @(negedge clk_32f);
      #1;
      if (started) begin
        if (rst_q) begin
          check("reset_outs", 32'({sym_start, ready_out, data_out}), 32'd0);
          pos  = -1;
          widx = 0;
        end else begin
          if (pos == WIDTH) begin
            if (q.size() > 0 && q[0].slot == widx) begin
              expw = q[0].word;
              void'(q.pop_front());
            end else begin
              expw = IDLE_ALL;
            end
            check($sformatf("word%0d", widx), 32'(mw), 32'(expw));
            check("sym_cadence", 32'(sym_start), 32'd1);
            widx++;
            pos = 0;
          end else if (pos > 0) begin
            check("sym_gap", 32'(sym_start), 32'd0);
          end
          if (pos < 0 && sym_start) pos = 0;
          if (pos >= 0) begin
            for (int k = 0; k < LANES; k++) begin
`ifdef PS_LSB_FIRST_EN
              mw[k*8 +: 8] = {data_out[k], mw[k*8+1 +: 7]};
`else
              mw[k*8 +: 8] = {mw[k*8 +: 7], data_out[k]};
`endif
            end
            pos++;
          end
        end
      end
    end
  end

  // Issue one word at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [15:0] w);
    int n = 0;
    data_in  = w;
    valid_in = 1'b1;
    while (!ready_out && n < 4 * WIDTH) begin
      @(negedge clk_32f);
      n++;
    end
    if (!ready_out) begin
      check("send_timeout", 32'd0, 32'd1);
      valid_in = 1'b0;
    end else begin
      q.push_back('{slot: cyc / WIDTH + 1, word: w});
      @(negedge clk_32f);
      valid_in = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] ib;
    logic       b;
    ib = IDLE;

    // Reset for 3 edges, then release.
    reset = 1'b1;
    repeat (3) @(negedge clk_32f);
    reset = 1'b0;

    // Preamble: two IDLE words, sym_start every 8th cycle, ready after 2nd load.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_32f);
`ifdef PS_LSB_FIRST_EN
      b = ib[i % 8];
`else
      b = ib[7 - (i % 8)];
`endif
      check($sformatf("sync_bit%0d", i), 32'(data_out), 32'({b, b}));
      check($sformatf("sync_sym%0d", i), 32'(sym_start), 32'((i % 8) == 0));
      check($sformatf("sync_rdy%0d", i), 32'(ready_out), 32'(i >= 8));
    end

    // Back-to-back words: lane0 A5 then 3C, lane1 5A then C3.
    send(16'h5AA5);
    check("ready_drop", 32'(ready_out), 32'd0);
    send(16'hC33C);

    // Source goes idle: only IDLE words follow.
    repeat (5 * WIDTH) @(negedge clk_32f);
    check("queue_drain", 32'(q.size()), 32'd0);

    // Reset mid-word with 0F waiting in the hold buffer.
    send(16'h5AA5);
    send(16'hF00F);
    repeat (4) @(negedge clk_32f);
    reset = 1'b1;
    q.delete();
    @(negedge clk_32f);
    check("rst_mid_dout", 32'(data_out), 32'd0);
    check("rst_mid_rdy", 32'(ready_out), 32'd0);
    repeat (2) @(negedge clk_32f);
    reset = 1'b0;
    repeat (6 * WIDTH) @(negedge clk_32f);
    check("final_queue", 32'(q.size()), 32'd0);
    check("final_rdy", 32'(ready_out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
